// File: rtl/sram22_arb2_if.sv
// Requester-side bus of sram22_arb2: two packed request ports plus tagged read responses.
// master = the two bus clients (driven together), slave = the arbiter.
interface sram22_arb2_if #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int WMASK_WIDTH = 8
);
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0]               req_we;
    logic [2*WMASK_WIDTH-1:0] req_wmask;
    logic [2*ADDR_WIDTH-1:0]  req_addr;
    logic [2*DATA_WIDTH-1:0]  req_wdata;
    logic [1:0]               rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram22_arb2.sv
// Two-port round-robin arbiter/sequencer driving a single-port sram22 macro from flops.
// Define SRAM22_ARB_FIXED_PRIO_EN for strict port-0 priority (no rotating pointer).
module sram22_arb2 #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int WMASK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    sram22_arb2_if.slave           bus,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    generate
        if (DATA_WIDTH != WMASK_WIDTH) begin : g_bad_cfg
            $error("sram22_arb2: DATA_WIDTH must equal WMASK_WIDTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0]  addr_arr  [2];
    logic [DATA_WIDTH-1:0]  wdata_arr [2];
    logic [WMASK_WIDTH-1:0] wmask_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wmask_arr[gi] = bus.req_wmask[gi*WMASK_WIDTH +: WMASK_WIDTH];
        end
    endgenerate

    logic                   prio;
    logic [1:0]             grant;
    logic                   accept;
    logic                   sel;
    logic                   ce_reg;
    logic                   we_reg;
    logic [WMASK_WIDTH-1:0] wmask_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DATA_WIDTH-1:0]  din_reg;
    logic                   pend_reg;
    logic                   tag_reg;
    logic [1:0]             rsp_valid_reg;

    // Grant is masked while in reset so nothing looks accepted during rstb=0.
    always_comb begin
        grant = 2'b00;
        if (rstb) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept = |grant;
    assign sel    = grant[1];

`ifdef SRAM22_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    logic prio_reg;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prio_reg <= 1'b0;
        end else if (accept) begin
            prio_reg <= ~sel;
        end
    end

    assign prio = prio_reg;
`endif

    // Stage 1 launches the access into macro-facing flops; stage 2 turns a pending read into its response pulse.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ce_reg        <= 1'b0;
            we_reg        <= 1'b0;
            wmask_reg     <= '0;
            addr_reg      <= '0;
            din_reg       <= '0;
            pend_reg      <= 1'b0;
            tag_reg       <= 1'b0;
            rsp_valid_reg <= 2'b00;
        end else begin
            if (accept) begin
                ce_reg    <= 1'b1;
                we_reg    <= bus.req_we[sel];
                wmask_reg <= wmask_arr[sel];
                addr_reg  <= addr_arr[sel];
                din_reg   <= wdata_arr[sel];
                pend_reg  <= ~bus.req_we[sel];
                tag_reg   <= sel;
            end else begin
                ce_reg   <= 1'b0;
                pend_reg <= 1'b0;
            end
            rsp_valid_reg <= {pend_reg & tag_reg, pend_reg & ~tag_reg};
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = sram_dout;
    assign sram_ce       = ce_reg;
    assign sram_we       = we_reg;
    assign sram_wmask    = wmask_reg;
    assign sram_addr     = addr_reg;
    assign sram_din      = din_reg;
endmodule

// File: tb/tb_sram22_arb2.sv
// Bench for sram22_arb2: behavioural sram22 macro, reference memory and a response scoreboard.
module tb_sram22_arb2;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MW = 8;
`ifdef SRAM22_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rstb;
    logic          sram_ce;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    logic [DW-1:0] mem     [1<<AW] = '{default: 8'h00};
    logic [DW-1:0] ref_mem [1<<AW] = '{default: 8'h00};
    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    sram22_arb2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) bus ();

    sram22_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .bus        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: samples registered inputs at the edge after they are launched.
    always @(posedge clk) begin
        if (rstb && sram_ce) begin
            if (sram_we)
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
            else
                sram_dout <= mem[sram_addr];
        end
    end

    // Scoreboard: accepts push expected read data in order; responses pop and compare.
    logic [1:0]    mon_acc;
    logic          mon_p;
    logic [AW-1:0] mon_a;
    logic [DW-1:0] mon_d;
    logic [MW-1:0] mon_m;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
        end else begin
            n_tests++;
            if (bus.req_ready === 2'b11) begin
                n_fail++;
                $display("FAIL ready_onehot: req_ready=%b required not 11", bus.req_ready);
            end
            if (bus.rsp_valid !== 2'b00) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b rdata=%h required no response", bus.rsp_valid, bus.rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.rsp_valid !== (mon_e.port ? 2'b10 : 2'b01) || bus.rsp_rdata !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL rsp_data: rsp_valid=%b rdata=%h required valid=%b rdata=%h",
                                 bus.rsp_valid, bus.rsp_rdata, mon_e.port ? 2'b10 : 2'b01, mon_e.data);
                    end
                end
            end
            mon_acc = bus.req_valid & bus.req_ready;
            if (mon_acc !== 2'b00) begin
                mon_p = mon_acc[1];
                mon_a = bus.req_addr[mon_p*AW +: AW];
                mon_d = bus.req_wdata[mon_p*DW +: DW];
                mon_m = bus.req_wmask[mon_p*MW +: MW];
                if (bus.req_we[mon_p])
                    ref_mem[mon_a] = (ref_mem[mon_a] & ~mon_m) | (mon_d & mon_m);
                else
                    exp_q.push_back('{port: mon_p, data: ref_mem[mon_a]});
            end
        end
    end

    task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        bit done = 1'b0;
        bus.req_we[p]             = we;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_wdata[p*DW +: DW] = d;
        bus.req_wmask[p*MW +: MW] = m;
        bus.req_valid[p]          = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid[p] = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: port %0d addr %h not accepted within 20 cycles", p, a);
        end
    endtask

    task automatic test_reset();
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.req_valid = 2'b11;
        rstb = 1'b1;
        #1 rstb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.req_ready !== 2'b00 || sram_ce !== 1'b0 || bus.rsp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state: ready=%b ce=%b rsp_valid=%b required 00/0/00",
                         bus.req_ready, sram_ce, bus.rsp_valid);
            end
        end
        @(posedge clk);
        #1 rstb = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b required 01", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
    endtask

    task automatic test_single_rw();
        repeat (3) @(posedge clk);
        #1;
        bus.req_we[0] = 1'b1;
        bus.req_addr[0 +: AW] = 9'h1A5;
        bus.req_wdata[0 +: DW] = 8'hC3;
        bus.req_wmask[0 +: MW] = 8'hFF;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rw_write_ready: req_ready=%b required 01", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_we[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sram_ce !== 1'b1 || sram_we !== 1'b1 || bus.req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rw_write_issue: ce=%b we=%b ready=%b required 1/1/01", sram_ce, sram_we, bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sram_ce !== 1'b1 || sram_we !== 1'b0 || bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rw_read_issue: ce=%b we=%b rsp_valid=%b required 1/0/00", sram_ce, sram_we, bus.rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL rw_read_rsp: rsp_valid=%b rdata=%h required 01/c3", bus.rsp_valid, bus.rsp_rdata);
        end
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 2'b00 || sram_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_pulse_end: rsp_valid=%b ce=%b required 00/0", bus.rsp_valid, sram_ce);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ready;
        @(posedge clk);
        #1;
        issue(0, 1'b1, 9'h010, 8'h11, 8'hFF);
        issue(1, 1'b1, 9'h020, 8'h22, 8'hFF);
        bus.req_we = 2'b00;
        bus.req_addr = {9'h020, 9'h010};
        bus.req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_ready = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: req_ready=%b required %b", k, bus.req_ready, exp_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL contention_drain: %0d responses outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_masked_write();
        @(posedge clk);
        #1;
        issue(0, 1'b1, 9'h003, 8'h00, 8'hFF);
        issue(1, 1'b1, 9'h003, 8'hFF, 8'h0F);
        issue(0, 1'b0, 9'h003, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'h0F) begin
            n_fail++;
            $display("FAIL masked_write: rsp_valid=%b rdata=%h required 01/0f", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int         issued = 0;
        int         cyc    = 0;
        logic [1:0] acc;
        @(posedge clk);
        #1;
        while ((issued < 200 || bus.req_valid != 2'b00) && cyc < 3000) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) bus.req_valid[p] = 1'b0;
                if (!bus.req_valid[p] && issued < 200 && $urandom_range(0, 3) != 0) begin
                    bus.req_we[p]             = 1'($urandom_range(0, 1));
                    bus.req_addr[p*AW +: AW]  = AW'($urandom_range(0, 31));
                    bus.req_wdata[p*DW +: DW] = DW'($urandom);
                    bus.req_wmask[p*MW +: MW] = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
                    bus.req_valid[p]          = 1'b1;
                    issued++;
                end
            end
        end
        if (cyc >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_timeout: %0d requests issued, traffic did not drain", issued);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_lost: %0d responses outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk);
        #1;
        issue(0, 1'b0, 9'h1A5, 8'h00, 8'h00);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.rsp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_no_rsp[%0d]: rsp_valid=%b required 00", i, bus.rsp_valid);
            end
        end
        @(posedge clk);
        #1;
        issue(0, 1'b0, 9'h1A5, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 8'hC3) begin
            n_fail++;
            $display("FAIL midreset_read: rsp_valid=%b rdata=%h required 01/c3", bus.rsp_valid, bus.rsp_rdata);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain: %0d responses outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_rw();
        test_contention();
        test_masked_write();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram22_arb2.md
Name: sram22_arb2

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port sram22 macro (clk, rstb, ce, we, wmask, addr, din, dout).
- Each requester issues reads and bit-masked writes through a valid/ready handshake; reads return tagged responses.
- All macro inputs are driven from flops, giving a clean setup window at the macro.
- Sits between two bus-side clients (e.g. core and DMA) and the macro.

Parameters:
- ADDR_WIDTH, 9, macro address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 8, macro word width
- WMASK_WIDTH, 8, write-mask width; DATA_WIDTH must equal WMASK_WIDTH (one mask bit per data bit)

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port accept; transfer when valid&ready at posedge
- req_we  in  2  per-port 1=write, 0=read
- req_wmask  in  2*WMASK_WIDTH  per-port write mask, port i at [i*W +: W]
- req_addr  in  2*ADDR_WIDTH  per-port address
- req_wdata  in  2*DATA_WIDTH  per-port write data
- rsp_valid  out  2  per-port read-data valid, one-cycle pulse
- rsp_rdata  out  DATA_WIDTH  read data, shared; qualified by rsp_valid
- sram_ce  out  1  macro chip enable (registered)
- sram_we  out  1  macro write enable (registered)
- sram_wmask  out  WMASK_WIDTH  macro write mask (registered)
- sram_addr  out  ADDR_WIDTH  macro address (registered)
- sram_din  out  DATA_WIDTH  macro write data (registered)
- sram_dout  in  DATA_WIDTH  macro read data

Behaviour:
- The integration ties the macro rstb to the same rstb as this block.
- Reset (async, rstb=0):
  - sram_ce, sram_we, sram_wmask, sram_addr, sram_din = 0.
  - rsp_valid = 0; internal pending-read flag and tag = 0.
  - Priority pointer prio = 0 (port 0 favoured).
- Grant (combinational from req_valid and prio):
  - One valid port: grant it.
  - Both valid: grant port prio.
  - req_ready = one-hot grant; 0 when no port is valid. Never both bits high.
- Pointer update: on any accepted transfer to port p, prio <= ~p at the same edge. No accept: prio holds.
- Accept edge N (stage 1):
  - sram_ce <= 1; sram_we/wmask/addr/din <= granted port's fields.
  - If read: pend <= 1, tag <= p. Else pend <= 0.
- No accept at edge N: sram_ce <= 0, pend <= 0. Other sram_* hold their values (don't-care while ce=0).
- Edge N+1 (stage 2): macro samples. For a read, rsp_valid[tag] <= 1 at this edge; all other rsp_valid bits <= 0.
- rsp_rdata = sram_dout (combinational passthrough), valid in the cycle after edge N+1.
- Read latency: 2 cycles from the accept edge. Throughput: one accept per cycle, fully pipelined, no bubbles.
- Writes produce no response. A write with wmask=0 still occupies a slot and arbitrates normally.
- Ordering: strict acceptance order through the macro.
  - A read accepted the cycle after a write to the same address returns the new data: the write commits at N+1, the read samples at N+2. No forwarding logic.
- Requesters must hold request fields stable while valid && !ready. Dropping valid before ready is permitted; nothing is issued for that port.
- Reset mid-operation: pending reads are discarded and no rsp_valid fires after rstb rises. The first request after reset is accepted on the first rising edge with rstb=1.

Optional Feature:
- Macro: SRAM22_ARB_FIXED_PRIO_EN.
- Defined: strict fixed priority, port 0 always wins when both are valid. prio register is removed; port 1 may starve.
- Undefined (default): round-robin behaviour as specified above.

Test Plan:
- Reset: hold rstb=0 with both valids high -> req_ready=00, sram_ce=0, rsp_valid=00. Release -> first accept goes to port 0.
- Single write then read, port 0:
  - Write addr=0x1A5, wdata=0xC3, wmask=0xFF, then read 0x1A5 next cycle.
  - Required: sram_ce high on two consecutive cycles; rsp_valid=01 exactly 2 cycles after the read accept; rsp_rdata=0xC3.
- Contention: both ports hold continuous reads (port 0 addr 0x010, port 1 addr 0x020, preloaded 0x11/0x22).
  - Required: grants alternate 0,1,0,1 starting with port 0; responses 0x11 and 0x22 alternate with the matching rsp_valid bit.
  - With SRAM22_ARB_FIXED_PRIO_EN defined: port 0 receives every grant.
- Masked write: preload 0x00 at addr 0x003; port 1 writes 0xFF with wmask=0x0F; port 0 reads 0x003 the next cycle -> rsp_rdata=0x0F on rsp_valid=01.
- Back-to-back mixed traffic: 200 random reads/writes on both ports vs a reference memory model.
  - Required: every read matches, no response is lost or duplicated, and req_ready is never 11.
- Reset mid-read: assert rstb=0 one cycle after a read accept -> no rsp_valid pulse after release; the next read returns correct data.
